// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath package: FSM state encoding and the sizing
// and operand-extension helpers used by the sequential Booth multiplier.
package arith_pkg;

  // Widest operand the extension helper supports. The helper's result is
  // MAX_W+1 bits wide, which leaves room for one extension bit.
  localparam int MAX_W = 64;
  localparam int MAX_E = MAX_W + 1;

  // Control states of the iterative multiplier.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of the iteration counter. The counter runs 0..E with E = WIDTH+1,
  // so it must be able to hold E+1 distinct values.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

  // Extend a WIDTH-bit operand (passed zero-padded to MAX_W bits) to
  // MAX_W+1 bits. In signed mode bit WIDTH-1 is replicated into every
  // higher bit; in unsigned mode the higher bits are zero. The caller keeps
  // only the low WIDTH+1 bits.
  function automatic logic [MAX_W:0] ext_operand(input logic [MAX_W-1:0] v,
                                                 input int unsigned  width,
                                                 input logic         sgn);
    logic [MAX_W:0] v_pad;
    logic [MAX_W:0] msb_sel;
    logic [MAX_W:0] hi_mask;
    logic           fill;
    v_pad   = {1'b0, v};
    msb_sel = v_pad & (MAX_E'(1) << (width - 1));
    fill    = sgn & (|msb_sel);
    hi_mask = {MAX_E{1'b1}} << width;
    return (v_pad & ~hi_mask) | ({MAX_E{fill}} & hi_mask);
  endfunction

endpackage : arith_pkg

// File: rtl/booth_mul_seq_if.sv
// Handshake bundle of the sequential Booth multiplier: an operand channel
// (in_valid/in_ready carrying x, y, is_signed) and a product channel
// (out_valid/out_ready carrying z).
interface booth_mul_seq_if #(
  parameter int WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic               is_signed;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] z;

  // Side that supplies operands and consumes products.
  modport master (
    output in_valid, is_signed, x, y, out_ready,
    input  in_ready, out_valid, z
  );

  // The multiplier itself.
  modport slave (
    input  in_valid, is_signed, x, y, out_ready,
    output in_ready, out_valid, z
  );

endinterface : booth_mul_seq_if

// File: rtl/booth_mul_seq_booth_step.sv
// One radix-2 Booth iteration over E-bit registers: conditional add or
// subtract of the multiplicand into the accumulator, followed by an
// arithmetic right shift of the combined {A, Q, q_m1} register.
module booth_step #(
  parameter int E = 5
) (
  input  logic [E-1:0] i_a,
  input  logic [E-1:0] i_q,
  input  logic         i_qm1,
  input  logic [E-1:0] i_y,
  output logic [E-1:0] o_a,
  output logic [E-1:0] o_q,
  output logic         o_qm1
);

  logic [E-1:0] w_sum;

  // Select the Booth action from the current bit pair and shift the result.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    w_sum = i_a;
    unique case ({i_q[0], i_qm1})
      2'b10:   w_sum = i_a - i_y;  // start of a run of ones: subtract
      2'b01:   w_sum = i_a + i_y;  // end of a run of ones: add back
      default: w_sum = i_a;        // inside a run of 0s or 1s: no change
    endcase
    // Arithmetic shift of {A, Q, q_m1}: A's sign bit is replicated on top,
    // A's LSB drops into Q, and Q's LSB becomes the new q_m1.
    {o_a, o_q, o_qm1} = {w_sum[E-1], w_sum, i_q};
  end

endmodule : booth_step

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier, one multiplier bit per clock.
// Operands are widened by one bit (sign- or zero-extended per transaction),
// so signed and unsigned products, including most-negative squared, come
// out exact with no correction step. Valid/ready handshakes on both sides;
// every output is driven straight from a flop.
module booth_mul_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_mul_seq_if.slave bus
);

  // Internal datapath width: one guard bit above the operand width lets the
  // negation of the most-negative operand be represented.
  localparam int E  = WIDTH + 1;
  localparam int CW = cnt_width(WIDTH);

  state_e             r_state;
  state_e             w_state_nxt;

  logic [E-1:0]       r_a;
  logic [E-1:0]       r_q;
  logic               r_qm1;
  logic [E-1:0]       r_y;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_z;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [E-1:0]       w_xext;
  logic [E-1:0]       w_yext;
  logic [E-1:0]       w_a_nxt;
  logic [E-1:0]       w_q_nxt;
  logic               w_qm1_nxt;
  logic               w_last;
  logic               w_accept;

  // Operands widened to E bits according to the mode sampled on accept.
  assign w_xext = E'(ext_operand(MAX_W'(bus.x), WIDTH, bus.is_signed));
  assign w_yext = E'(ext_operand(MAX_W'(bus.y), WIDTH, bus.is_signed));

  // All E iterations are complete once the counter has reached E.
  assign w_last   = (r_cnt == CW'(E));
  assign w_accept = (r_state == IDLE) && bus.in_valid;

  booth_step #(
    .E (E)
  ) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_qm1 (r_qm1),
    .i_y   (r_y),
    .o_a   (w_a_nxt),
    .o_q   (w_q_nxt),
    .o_qm1 (w_qm1_nxt)
  );

  // Next-state decode: accept in IDLE, iterate in RUN, wait for the
  // consumer in DONE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
      RUN:     if (w_last)        w_state_nxt = DONE;
      DONE:    if (bus.out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register plus the handshake flags, registered from the next state
  // so in_ready and out_valid have no combinational path from any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of statement order.
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
    end
  end

  // Datapath: load on accept, one Booth step per RUN cycle, capture the
  // product on the cycle after the last step. z is untouched otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every datapath register is cleared by reset (no arrays here),
      // so an aborted operation can never surface a partial product.
      r_a   <= '0;
      r_q   <= '0;
      r_qm1 <= 1'b0;
      r_y   <= '0;
      r_cnt <= '0;
      r_z   <= '0;
    end else begin
      if (w_accept) begin
        r_a   <= '0;
        r_q   <= w_xext;
        r_qm1 <= 1'b0;
        r_y   <= w_yext;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        if (w_last) begin
          // Low 2*WIDTH bits of {A, Q}: A contributes its WIDTH-1 low bits.
          r_z <= {r_a[WIDTH-2:0], r_q};
        end else begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= w_qm1_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.z         = r_z;

endmodule : booth_mul_seq

// File: tb/tb_booth_mul_seq.sv
// Bench for booth_mul_seq: directed WIDTH=4 cases (signed/unsigned, corner
// products, backpressure, reset mid-run) and a WIDTH=8 sweep of corner and
// random operand pairs against an integer-multiply reference.
module tb_booth_mul_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  booth_mul_seq_if #(.WIDTH(4)) b4 ();
  booth_mul_seq_if #(.WIDTH(8)) b8 ();

  booth_mul_seq #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4.slave)
  );

  booth_mul_seq #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  int errors = 0;
  int checks = 0;

  // Scoreboards: expected products queued on accept, popped on out_valid.
  logic [7:0]  q4[$];
  logic [15:0] q8[$];

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference product of two 8-bit operands, low 16 bits.
  function automatic logic [15:0] model8(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic s);
    longint ai;
    longint bi;
    ai = s ? longint'($signed(a)) : longint'(a);
    bi = s ? longint'($signed(b)) : longint'(b);
    return 16'(ai * bi);
  endfunction

  // One WIDTH=4 transaction. If hold > 0 the consumer stalls for that many
  // cycles after out_valid while in_valid is pulsed with junk operands.
  task automatic run4(input logic [3:0] x, input logic [3:0] y,
                      input logic s, input logic [7:0] exp_z,
                      input string tag, input int hold);
    int n;
    int lat;
    bit busy_ok;
    logic [7:0] e;
    b4.x         = x;
    b4.y         = y;
    b4.is_signed = s;
    b4.in_valid  = 1'b1;
    b4.out_ready = (hold == 0);
    n = 0;
    while (b4.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, " in_ready"}, 64'(b4.in_ready), 64'd1);
    step();  // accept edge
    b4.in_valid = 1'b0;
    b4.x        = 4'h0;
    b4.y        = 4'h0;
    q4.push_back(exp_z);
    lat     = 0;
    busy_ok = 1'b1;
    do begin
      step();
      lat++;
      if (b4.in_ready !== 1'b0) busy_ok = 1'b0;
    end while (b4.out_valid !== 1'b1 && lat < 100);
    check({tag, " latency"}, 64'(lat), 64'd6);
    check({tag, " busy"}, 64'(busy_ok), 64'd1);
    e = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
    check({tag, " z"}, 64'(b4.z), 64'(e));
    for (int i = 0; i < hold; i++) begin
      b4.in_valid = (i % 2 == 0);
      b4.x        = 4'(i);
      b4.y        = 4'(i + 3);
      step();
      check({tag, " hold out_valid"}, 64'(b4.out_valid), 64'd1);
      check({tag, " hold z"}, 64'(b4.z), 64'(e));
      check({tag, " hold in_ready"}, 64'(b4.in_ready), 64'd0);
    end
    b4.in_valid  = 1'b0;
    b4.out_ready = 1'b1;
    step();
    check({tag, " out_valid drop"}, 64'(b4.out_valid), 64'd0);
    check({tag, " idle"}, 64'(b4.in_ready), 64'd1);
  endtask

  // One WIDTH=8 transaction with the consumer always ready.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic s);
    int n;
    int lat;
    logic [15:0] e;
    b8.x         = x;
    b8.y         = y;
    b8.is_signed = s;
    b8.in_valid  = 1'b1;
    b8.out_ready = 1'b1;
    n = 0;
    while (b8.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    step();  // accept edge (fails the latency check below if never ready)
    b8.in_valid = 1'b0;
    q8.push_back(model8(x, y, s));
    lat = 0;
    do begin
      step();
      lat++;
    end while (b8.out_valid !== 1'b1 && lat < 100);
    check($sformatf("w8 %0h*%0h s=%0d latency", x, y, s), 64'(lat), 64'd10);
    e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
    check($sformatf("w8 %0h*%0h s=%0d z", x, y, s), 64'(b8.z), 64'(e));
    step();  // handshake edge, back to IDLE
  endtask

  // Absolute bound on the whole run.
  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] corners [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};

  initial begin
    b4.in_valid = 1'b0; b4.is_signed = 1'b0; b4.x = '0; b4.y = '0;
    b4.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.is_signed = 1'b0; b8.x = '0; b8.y = '0;
    b8.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset in_ready",  64'(b4.in_ready),  64'd1);
    check("reset out_valid", 64'(b4.out_valid), 64'd0);
    check("reset z",         64'(b4.z),         64'd0);
    check("reset w8 z",      64'(b8.z),         64'd0);
    rst_n = 1'b1;
    step();

    // Directed WIDTH=4 products.
    run4(4'h3, 4'hE, 1'b1, 8'hFA, "s 3*-2",   0);
    run4(4'h8, 4'h8, 1'b1, 8'h40, "s -8*-8",  0);
    run4(4'h8, 4'h7, 1'b1, 8'hC8, "s -8*7",   0);
    run4(4'hF, 4'hF, 1'b0, 8'hE1, "u 15*15",  0);
    run4(4'hF, 4'hF, 1'b1, 8'h01, "s -1*-1",  0);

    // Backpressure, then a fresh accept straight after.
    run4(4'h6, 4'h5, 1'b0, 8'h1E, "bp 6*5",   10);
    run4(4'h9, 4'h3, 1'b1, 8'hEB, "bp next",  0);

    // Reset two steps into a run: no partial result, z cleared.
    b4.x = 4'h7; b4.y = 4'h3; b4.is_signed = 1'b0; b4.in_valid = 1'b1;
    step();  // accept edge
    b4.in_valid = 1'b0;
    q4.push_back(8'h15);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("midrun reset out_valid", 64'(b4.out_valid), 64'd0);
    check("midrun reset in_ready",  64'(b4.in_ready),  64'd1);
    check("midrun reset z",         64'(b4.z),         64'd0);
    q4.delete();
    step();
    rst_n = 1'b1;
    step();
    run4(4'h5, 4'h5, 1'b0, 8'h19, "after reset 5*5", 0);

    // WIDTH=8: every corner pairing in both modes, then random pairs.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int s = 0; s < 2; s++)
          run8(corners[i], corners[j], 1'(s));
    for (int k = 0; k < 2000; k++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_booth_mul_seq
